// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the memory request arbiter.
//   arb_state_e : sequencer states (IDLE -> ISSUE -> WAIT_DONE -> RELEASE)
//   READ_REQ / WRITE_REQ : encodings of the per-requester rw bit
//   REQ_ICACHE / REQ_DCACHE / REQ_MMIO : requester slot indices
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  localparam logic READ_REQ  = 1'b0;
  localparam logic WRITE_REQ = 1'b1;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_MMIO   = 2;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector starting
// at index ptr_i and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   req_i     : request vector
//   ptr_i     : index with highest priority this round
//   onehot_o  : one-hot winner (all zero when nothing is requested)
//   idx_o     : binary index of the winner (0 when nothing is requested)
//   valid_o   : at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int k;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    k        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o     = 1'b1;
        idx_o       = IDX_W'(k);
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one AXI controller request port between NUM_REQ requesters
// (0 = icache, 1 = dcache, 2 = mmio). A round-robin winner is granted for
// a whole transaction, its command is latched onto the controller port,
// and a one-cycle done pulse is returned when the controller completes or
// the watchdog expires. All outputs are registered.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_i/rw_i            : per-requester request level and direction
//   addr_i/wdata_i/len_i  : packed per-requester command fields
//   gnt_o                 : one-hot grant, held ISSUE through WAIT_DONE
//   done_o                : one-cycle completion pulse to the winner
//   bus_ready_i           : controller can accept a new request
//   bus_req_o, bus_rw_o, bus_addr_o, bus_wdata_o, bus_len_o : latched command
//   bus_done_i            : controller completion (level or pulse)
//   timeout_err           : sticky watchdog flag, cleared only by rst
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  input  logic [NUM_REQ*8-1:0]  len_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  input  logic                  bus_ready_i,
  output logic                  bus_req_o,
  output logic                  bus_rw_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  output logic [7:0]            bus_len_o,
  input  logic                  bus_done_i,
  output logic                  timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT - 1);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               bus_req_q, bus_req_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [7:0]         len_q, len_d;
  logic [31:0]        wdog_q, wdog_d;
  logic               tout_q, tout_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    bus_req_d = bus_req_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    wdog_d    = wdog_q;
    tout_d    = tout_q;

    unique case (state_q)
      IDLE: begin
        bus_req_d = 1'b0;
        if (pick_valid && bus_ready_i) begin
          win_d   = pick_idx;
          gnt_d   = pick_onehot;
          rw_d    = rw_i[pick_idx];
          addr_d  = addr_i[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = wdata_i[pick_idx*DATA_W +: DATA_W];
          len_d   = len_i[pick_idx*8 +: 8];
          ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          wdog_d  = '0;
          state_d = ISSUE;
        end
      end

      // bus_req_o is registered, so it becomes visible while in WAIT_DONE.
      ISSUE: begin
        bus_req_d = 1'b1;
        state_d   = WAIT_DONE;
      end

      // Completion is checked before the watchdog so a simultaneous
      // done and expiry counts as a normal completion.
      WAIT_DONE: begin
        if (bus_done_i) begin
          done_d    = gnt_q;
          gnt_d     = '0;
          bus_req_d = 1'b0;
          state_d   = RELEASE;
        end else if (wdog_q == WDOG_LIMIT) begin
          tout_d    = 1'b1;
          done_d    = gnt_q;
          gnt_d     = '0;
          bus_req_d = 1'b0;
          state_d   = RELEASE;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      // Hold here until the finished requester drops its request, so a
      // stuck-high request cannot be granted twice for one transaction.
      RELEASE: begin
        if (!req_i[win_q]) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      bus_req_q <= 1'b0;
      rw_q      <= READ_REQ;
      addr_q    <= '0;
      wdata_q   <= '0;
      len_q     <= '0;
      wdog_q    <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      bus_req_q <= bus_req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      len_q     <= len_d;
      wdog_q    <= wdog_d;
      tout_q    <= tout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign bus_req_o   = bus_req_q;
  assign bus_rw_o    = rw_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_len_o   = len_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter with a short watchdog (TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so each tick() advances exactly one registered cycle.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 16;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        rw_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ*8-1:0]      len_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic                      bus_ready_i;
  logic                      bus_req_o;
  logic                      bus_rw_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [DATA_W-1:0]         bus_wdata_o;
  logic [7:0]                bus_len_o;
  logic                      bus_done_i;
  logic                      timeout_err;

  int checks;
  int errors;

  mem_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .rw_i        (rw_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .len_i       (len_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .bus_ready_i (bus_ready_i),
    .bus_req_o   (bus_req_o),
    .bus_rw_o    (bus_rw_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_len_o   (bus_len_o),
    .bus_done_i  (bus_done_i),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [7:0] len);
    rw_i[k]                   = rw;
    addr_i[k*ADDR_W +: ADDR_W] = a;
    wdata_i[k*DATA_W +: DATA_W] = wd;
    len_i[k*8 +: 8]           = len;
  endtask

  task automatic do_reset();
    req_i       = '0;
    rw_i        = '0;
    addr_i      = '0;
    wdata_i     = '0;
    len_i       = '0;
    bus_ready_i = 1'b1;
    bus_done_i  = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_o, done_o, bus_req_o, bus_rw_o, timeout_err} !== '0 ||
        bus_addr_o !== '0 || bus_wdata_o !== '0 || bus_len_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: gnt=%b done=%b req=%b addr=%h len=%0d tout=%b, expected all zero",
               gnt_o, done_o, bus_req_o, bus_addr_o, bus_len_o, timeout_err);
    end
  endtask

  // Single read from icache: grant at cycle 1, bus_req at cycle 2,
  // bus_done during cycle 10, done pulse at cycle 11.
  task automatic test_single_read();
    do_reset();
    set_cmd(REQ_ICACHE, READ_REQ, 64'h8000_0000, 64'h0, 8'd8);
    req_i = 3'b001;
    tick();
    checks++;
    if (gnt_o !== 3'b001 || bus_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt=%b req=%b, expected gnt=001 req=0", gnt_o, bus_req_o);
    end
    tick();
    checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 64'h8000_0000 || bus_len_o !== 8'd8 || bus_rw_o !== READ_REQ) begin
      errors++;
      $display("[TB] FAIL single_issue: req=%b addr=%h len=%0d rw=%b, expected 1 80000000 8 0",
               bus_req_o, bus_addr_o, bus_len_o, bus_rw_o);
    end
    for (int c = 3; c <= 10; c++) tick();
    checks++;
    if (done_o !== 3'b000 || bus_req_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_waiting: done=%b req=%b, expected 000 1", done_o, bus_req_o);
    end
    bus_done_i = 1'b1;
    tick();
    bus_done_i = 1'b0;
    req_i      = 3'b000;
    checks++;
    if (done_o !== 3'b001 || bus_req_o !== 1'b0 || gnt_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_done: done=%b req=%b gnt=%b, expected 001 0 000", done_o, bus_req_o, gnt_o);
    end
    tick();
    checks++;
    if (done_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_done_pulse: done=%b, expected 000", done_o);
    end
    // A completion level seen while idle must not produce a pulse.
    bus_done_i = 1'b1;
    tick();
    tick();
    bus_done_i = 1'b0;
    checks++;
    if (done_o !== 3'b000 || gnt_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_done_ignored: done=%b gnt=%b, expected 000 000", done_o, gnt_o);
    end
  endtask

  // All three request; each is served, drops one cycle after done, then
  // re-requests. Expected grant order 0,1,2,0.
  task automatic test_fairness();
    int order [4];
    logic [NUM_REQ-1:0] exp_oh;
    bit seen;
    order = '{0, 1, 2, 0};
    do_reset();
    set_cmd(REQ_ICACHE, READ_REQ,  64'h1000, 64'h0,    8'd4);
    set_cmd(REQ_DCACHE, WRITE_REQ, 64'h2000, 64'hAAAA, 8'd1);
    set_cmd(REQ_MMIO,   READ_REQ,  64'h3000, 64'h0,    8'd1);
    req_i = 3'b111;
    for (int r = 0; r < 4; r++) begin
      exp_oh = '0;
      exp_oh[order[r]] = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        tick();
        if (gnt_o !== 3'b000) seen = 1'b1;
      end
      checks++;
      if (gnt_o !== exp_oh) begin
        errors++;
        $display("[TB] FAIL fair_grant_%0d: gnt=%b, expected %b", r, gnt_o, exp_oh);
      end
      tick();
      checks++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 64'(64'h1000 * (order[r] + 1))) begin
        errors++;
        $display("[TB] FAIL fair_cmd_%0d: req=%b addr=%h, expected 1 %h",
                 r, bus_req_o, bus_addr_o, 64'h1000 * (order[r] + 1));
      end
      bus_done_i = 1'b1;
      tick();
      bus_done_i = 1'b0;
      checks++;
      if (done_o !== exp_oh) begin
        errors++;
        $display("[TB] FAIL fair_done_%0d: done=%b, expected %b", r, done_o, exp_oh);
      end
      tick();
      req_i[order[r]] = 1'b0;
      tick();
      req_i[order[r]] = 1'b1;
    end
    req_i = '0;
  endtask

  // Controller busy: no grant while bus_ready_i=0; grant the cycle after
  // it rises. Then addr_i changes after the grant and must not leak through.
  task automatic test_busy_and_latch();
    int bad;
    do_reset();
    set_cmd(REQ_DCACHE, WRITE_REQ, 64'h4000_1234, 64'hCAFE, 8'd2);
    bus_ready_i = 1'b0;
    req_i = 3'b010;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (gnt_o !== 3'b000 || bus_req_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL busy_no_grant: %0d busy cycles had gnt or bus_req set, expected 0", bad);
    end
    bus_ready_i = 1'b1;
    tick();
    checks++;
    if (gnt_o !== 3'b010) begin
      errors++;
      $display("[TB] FAIL busy_grant: gnt=%b, expected 010", gnt_o);
    end
    addr_i[REQ_DCACHE*ADDR_W +: ADDR_W] = 64'hDEAD;
    rw_i[REQ_DCACHE] = READ_REQ;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus_addr_o !== 64'h4000_1234 || bus_rw_o !== WRITE_REQ || bus_wdata_o !== 64'hCAFE) bad++;
    end
    bus_done_i = 1'b1;
    tick();
    bus_done_i = 1'b0;
    if (bus_addr_o !== 64'h4000_1234) bad++;
    checks++;
    if (bad != 0 || done_o !== 3'b010) begin
      errors++;
      $display("[TB] FAIL latch_hold: %0d cycles lost latched cmd, addr=%h done=%b, expected 40001234 010",
               bad, bus_addr_o, done_o);
    end
    req_i = '0;
    tick();
  endtask

  // Controller never completes: done pulse and timeout_err 16 cycles after
  // entering WAIT_DONE; flag sticks until rst.
  task automatic test_timeout();
    int early;
    do_reset();
    set_cmd(REQ_MMIO, READ_REQ, 64'h9000, 64'h0, 8'd1);
    req_i = 3'b100;
    tick();
    checks++;
    if (gnt_o !== 3'b100) begin
      errors++;
      $display("[TB] FAIL tout_grant: gnt=%b, expected 100", gnt_o);
    end
    early = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      if (done_o !== 3'b000 || timeout_err !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL tout_early: %0d cycles showed done/timeout before expiry, expected 0", early);
    end
    tick();
    checks++;
    if (done_o !== 3'b100 || timeout_err !== 1'b1 || bus_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tout_expire: done=%b tout=%b req=%b, expected 100 1 0", done_o, timeout_err, bus_req_o);
    end
    req_i = '0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tout_sticky: tout=%b, expected 1", timeout_err);
    end
  endtask

  // Reset while waiting for completion: everything clears, and the pending
  // request set {1,2} is re-arbitrated from index 0, so requester 1 wins
  // (without the pointer reset, ptr=2 would favour requester 2).
  task automatic test_reset_mid();
    set_cmd(REQ_DCACHE, READ_REQ, 64'h5000, 64'h0, 8'd3);
    set_cmd(REQ_MMIO,   READ_REQ, 64'h6000, 64'h0, 8'd1);
    req_i = 3'b010;
    tick();
    tick();
    checks++;
    if (gnt_o !== 3'b010 || bus_req_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_setup: gnt=%b req=%b, expected 010 1", gnt_o, bus_req_o);
    end
    req_i = 3'b110;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({gnt_o, done_o, bus_req_o, bus_rw_o, timeout_err} !== '0 ||
        bus_addr_o !== '0 || bus_len_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rmid_clear: gnt=%b done=%b req=%b addr=%h tout=%b, expected all zero",
               gnt_o, done_o, bus_req_o, bus_addr_o, timeout_err);
    end
    tick();
    checks++;
    if (gnt_o !== 3'b010) begin
      errors++;
      $display("[TB] FAIL rmid_rearb: gnt=%b, expected 010", gnt_o);
    end
    req_i = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_single_read();
    test_fairness();
    test_busy_and_latch();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
